// File: rtl/seq_pattern_detector_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
// Holds the FSM state encoding, the default pattern width and the length clamp.
package seq_det_pkg;

    localparam int MAX_LEN_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HUNT = 2'd1
    } det_state_t;

    // A zero or oversized length selects the full pattern width.
    function automatic int clamp_len(input int len, input int max_len);
        return (len < 1 || len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Programmable serial bit-pattern detector with run-time pattern, length and
// overlap mode; counts matches in a saturating counter.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 8
) (
    input  logic               clk_2,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cnt_clear,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed,
    output logic [MAX_LEN-1:0] hist
);

    det_state_t         state_q, state_d;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic [MAX_LEN-1:0] hist_q, hist_d, hist_shift, len_mask;
    logic [LEN_W-1:0]   fill_q, fill_d, fill_inc;
    logic [LEN_W-1:0]   len_clamped;
    logic               hit;
    logic               match_p0, match_p1;

    assign len_clamped = LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));

    // Candidate view of the shift register if the current bit is accepted.
    assign hist_shift = {hist_q[MAX_LEN-2:0], in_bit};
    assign fill_inc   = (fill_q >= LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    assign len_mask   = ~({MAX_LEN{1'b1}} << len_q);
    assign hit        = (((hist_shift ^ pat_q) & len_mask) == '0) && (fill_inc >= len_q);

    always_comb begin
        state_d  = state_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        match_p0 = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_load) begin
                    state_d = S_HUNT;
                    hist_d  = '0;
                    fill_d  = '0;
                end
            end
            S_HUNT: begin
                // A reload drops any bit presented in the same cycle.
                if (cfg_load) begin
                    hist_d = '0;
                    fill_d = '0;
                end else if (in_valid) begin
                    hist_d   = hist_shift;
                    fill_d   = (hit && !overlap_q) ? '0 : fill_inc;
                    match_p0 = hit;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // p0 -> p1: detection result registered into the match pulse.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            len_q     <= LEN_W'(MAX_LEN);
            overlap_q <= 1'b1;
            hist_q    <= '0;
            fill_q    <= '0;
            match_p1  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            match_p1 <= match_p0;
            if (cfg_load) begin
                pat_q     <= cfg_pattern;
                len_q     <= len_clamped;
                overlap_q <= cfg_overlap;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk_2),
        .reset (reset),
        .clr   (cnt_clear),
        .inc   (match_p0),
        .q     (match_count)
    );

    assign match = match_p1;
    assign armed = (state_q == S_HUNT);
    assign hist  = hist_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector; a second instance with a 2-bit
// counter shares all inputs to exercise saturation.
module tb_seq_pattern_detector;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic               clk_2 = 1'b0;
    logic               reset;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               in_bit;
    logic               cnt_clear;

    logic               match, match_s;
    logic [7:0]         match_count;
    logic [1:0]         count_s;
    logic               armed, armed_s;
    logic [MAX_LEN-1:0] hist, hist_s;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_2 = ~clk_2;

    seq_pattern_detector #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(8)) dut (
        .clk_2(clk_2), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_bit(in_bit),
        .cnt_clear(cnt_clear), .match(match), .match_count(match_count), .armed(armed),
        .hist(hist)
    );

    seq_pattern_detector #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2)) dut_s (
        .clk_2(clk_2), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_bit(in_bit),
        .cnt_clear(cnt_clear), .match(match_s), .match_count(count_s), .armed(armed_s),
        .hist(hist_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic bit_in(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        tick();
        cfg_load    = 1'b0;
    endtask

    // bits[n-1] is sent first; exp[n-1] is the match expected after it.
    task automatic stream_chk(input string tag, input logic [15:0] bits,
                              input logic [15:0] exp, input int n);
        logic [15:0] b, e;
        b = bits;
        e = exp;
        for (int i = n - 1; i >= 0; i--) begin
            bit_in(b[i]);
            chk($sformatf("%s_m%0d", tag, n - i), {31'd0, match}, {31'd0, e[i]});
        end
    endtask

    initial begin
        reset = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        in_valid = 1'b0; in_bit = 1'b0; cnt_clear = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_match", {31'd0, match}, 32'd0);
        chk("rst_count", {24'd0, match_count}, 32'd0);
        chk("rst_armed", {31'd0, armed}, 32'd0);
        chk("rst_hist", {24'd0, hist}, 32'd0);

        // Unarmed: data ignored.
        stream_chk("idle", 16'b1011, 16'b0000, 4);
        chk("idle_armed", {31'd0, armed}, 32'd0);
        chk("idle_count", {24'd0, match_count}, 32'd0);
        chk("idle_hist", {24'd0, hist}, 32'd0);

        // Overlapping 1011.
        load(8'h0B, 4'd4, 1'b1);
        chk("ov_armed", {31'd0, armed}, 32'd1);
        stream_chk("ov", 16'b1011011, 16'b0001001, 7);
        chk("ov_count", {24'd0, match_count}, 32'd2);
        chk("ov_hist", {24'd0, hist}, 32'h5B);
        tick();
        chk("ov_gap_match", {31'd0, match}, 32'd0);
        cnt_clear = 1'b1; tick(); cnt_clear = 1'b0;
        chk("clr_count", {24'd0, match_count}, 32'd0);

        // Non-overlapping 1011; reload clears hist.
        load(8'h0B, 4'd4, 1'b0);
        chk("nov_hist_clr", {24'd0, hist}, 32'd0);
        stream_chk("nov", 16'b1011011, 16'b0001000, 7);
        chk("nov_count", {24'd0, match_count}, 32'd1);

        // 111 overlapping, saturation on the 2-bit counter.
        cnt_clear = 1'b1;
        load(8'h07, 4'd3, 1'b1);
        cnt_clear = 1'b0;
        stream_chk("ones", 16'b111111, 16'b001111, 6);
        chk("ones_count", {24'd0, match_count}, 32'd4);
        chk("ones_sat", {30'd0, count_s}, 32'd3);

        // Gap of invalid cycles inside the pattern.
        cnt_clear = 1'b1;
        load(8'h0B, 4'd4, 1'b1);
        cnt_clear = 1'b0;
        stream_chk("gap", 16'b101, 16'b000, 3);
        repeat (5) tick();
        chk("gap_match", {31'd0, match}, 32'd0);
        chk("gap_hist", {24'd0, hist}, 32'h05);
        bit_in(1'b1);
        chk("gap_last_match", {31'd0, match}, 32'd1);
        chk("gap_count", {24'd0, match_count}, 32'd1);

        // Mid-stream reset.
        stream_chk("pre_rst", 16'b101, 16'b000, 3);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("mrst_match", {31'd0, match}, 32'd0);
        chk("mrst_count", {24'd0, match_count}, 32'd0);
        chk("mrst_armed", {31'd0, armed}, 32'd0);
        chk("mrst_hist", {24'd0, hist}, 32'd0);
        bit_in(1'b1);
        chk("mrst_bit_match", {31'd0, match}, 32'd0);
        chk("mrst_bit_hist", {24'd0, hist}, 32'd0);

        // Load with a simultaneous valid bit: bit dropped.
        in_valid = 1'b1; in_bit = 1'b1;
        load(8'h01, 4'd1, 1'b0);
        in_valid = 1'b0;
        chk("ldv_match", {31'd0, match}, 32'd0);
        chk("ldv_hist", {24'd0, hist}, 32'd0);

        // Single-bit pattern, non-overlapping.
        stream_chk("len1", 16'b101, 16'b101, 3);
        chk("len1_count", {24'd0, match_count}, 32'd2);

        // Clear coinciding with a match.
        cnt_clear = 1'b1;
        bit_in(1'b1);
        cnt_clear = 1'b0;
        chk("clrm_match", {31'd0, match}, 32'd1);
        chk("clrm_count", {24'd0, match_count}, 32'd0);

        // cfg_len=0 selects the full 8-bit pattern.
        load(8'hA5, 4'd0, 1'b1);
        stream_chk("len0", 16'b10100101, 16'b00000001, 8);
        chk("len0_hist", {24'd0, hist}, 32'hA5);
        chk("len0_count", {24'd0, match_count}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
